// File: rtl/axi_simple_initiator.sv
// AXI4 manager that turns one command into one INCR burst (read or write),
// streams beat data through, and reports a single-cycle completion response.
// Only one transaction is outstanding at a time.
module axi_simple_initiator #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 1,
    parameter int AXI_ID_WIDTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    // command request
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [7:0]                    cmd_len,
    input  logic [2:0]                    cmd_size,
    input  logic [AXI_ID_WIDTH-1:0]       cmd_id,
    // write beat stream
    input  logic [AXI_DATA_WIDTH-1:0]     wr_data,
    input  logic [AXI_DATA_WIDTH/8-1:0]   wr_strb,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    // read beat stream
    output logic [AXI_DATA_WIDTH-1:0]     rd_data,
    output logic                          rd_last,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    // completion
    output logic                          rsp_valid,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_proto_err,
    // AW channel
    output logic [AXI_ID_WIDTH-1:0]       aw_id,
    output logic [AXI_ADDR_WIDTH-1:0]     aw_addr,
    output logic [AXI_USER_WIDTH-1:0]     aw_user,
    output logic [7:0]                    aw_len,
    output logic [2:0]                    aw_size,
    output logic [1:0]                    aw_burst,
    output logic                          aw_lock,
    output logic [3:0]                    aw_cache,
    output logic [2:0]                    aw_prot,
    output logic [3:0]                    aw_qos,
    output logic [3:0]                    aw_region,
    output logic [5:0]                    aw_atop,
    output logic                          aw_valid,
    input  logic                          aw_ready,
    // W channel
    output logic [AXI_DATA_WIDTH-1:0]     w_data,
    output logic [AXI_DATA_WIDTH/8-1:0]   w_strb,
    output logic [AXI_USER_WIDTH-1:0]     w_user,
    output logic                          w_last,
    output logic                          w_valid,
    input  logic                          w_ready,
    // B channel
    input  logic [AXI_ID_WIDTH-1:0]       b_id,
    input  logic [1:0]                    b_resp,
    input  logic [AXI_USER_WIDTH-1:0]     b_user,
    input  logic                          b_valid,
    output logic                          b_ready,
    // AR channel
    output logic [AXI_ID_WIDTH-1:0]       ar_id,
    output logic [AXI_ADDR_WIDTH-1:0]     ar_addr,
    output logic [AXI_USER_WIDTH-1:0]     ar_user,
    output logic [7:0]                    ar_len,
    output logic [2:0]                    ar_size,
    output logic [1:0]                    ar_burst,
    output logic                          ar_lock,
    output logic [3:0]                    ar_cache,
    output logic [2:0]                    ar_prot,
    output logic [3:0]                    ar_qos,
    output logic [3:0]                    ar_region,
    output logic                          ar_valid,
    input  logic                          ar_ready,
    // R channel
    input  logic [AXI_ID_WIDTH-1:0]       r_id,
    input  logic [AXI_DATA_WIDTH-1:0]     r_data,
    input  logic [1:0]                    r_resp,
    input  logic [AXI_USER_WIDTH-1:0]     r_user,
    input  logic                          r_last,
    input  logic                          r_valid,
    output logic                          r_ready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_AR   = 3'd4;
    localparam logic [2:0] S_R    = 3'd5;
    localparam logic [2:0] S_RSP  = 3'd6;

    logic [2:0]                r_state;
    logic [AXI_ADDR_WIDTH-1:0] r_txnAddr;
    logic [7:0]                r_txnLen;
    logic [2:0]                r_txnSize;
    logic [AXI_ID_WIDTH-1:0]   r_txnId;
    logic [7:0]                r_beatCnt;
    logic [1:0]                r_rspResp;
    logic                      r_rspErr;

    // State decodes are gated by rst so every valid/ready drops in the very
    // cycle reset is asserted, not one cycle later.
    logic w_inIdle, w_inAw, w_inW, w_inB, w_inAr, w_inR, w_inRsp;
    logic w_wrBeat, w_rdBeat, w_cntAtLen;
    logic w_unused;

    assign w_inIdle   = (r_state == S_IDLE) && !rst;
    assign w_inAw     = (r_state == S_AW)   && !rst;
    assign w_inW      = (r_state == S_W)    && !rst;
    assign w_inB      = (r_state == S_B)    && !rst;
    assign w_inAr     = (r_state == S_AR)   && !rst;
    assign w_inR      = (r_state == S_R)    && !rst;
    assign w_inRsp    = (r_state == S_RSP)  && !rst;
    assign w_cntAtLen = (r_beatCnt == r_txnLen);
    assign w_wrBeat   = w_inW && wr_valid && w_ready;
    assign w_rdBeat   = w_inR && r_valid && rd_ready;
    assign w_unused   = ^{b_user, r_user};

    assign cmd_ready     = w_inIdle;
    assign rsp_valid     = w_inRsp;
    assign rsp_resp      = r_rspResp;
    assign rsp_proto_err = r_rspErr;

    assign aw_id     = r_txnId;
    assign aw_addr   = r_txnAddr;
    assign aw_len    = r_txnLen;
    assign aw_size   = r_txnSize;
    assign aw_burst  = 2'b01;
    assign aw_user   = '0;
    assign aw_lock   = 1'b0;
    assign aw_cache  = 4'd0;
    assign aw_prot   = 3'd0;
    assign aw_qos    = 4'd0;
    assign aw_region = 4'd0;
    assign aw_atop   = 6'd0;
    assign aw_valid  = w_inAw;

    assign ar_id     = r_txnId;
    assign ar_addr   = r_txnAddr;
    assign ar_len    = r_txnLen;
    assign ar_size   = r_txnSize;
    assign ar_burst  = 2'b01;
    assign ar_user   = '0;
    assign ar_lock   = 1'b0;
    assign ar_cache  = 4'd0;
    assign ar_prot   = 3'd0;
    assign ar_qos    = 4'd0;
    assign ar_region = 4'd0;
    assign ar_valid  = w_inAr;

    assign w_data   = wr_data;
    assign w_strb   = wr_strb;
    assign w_user   = '0;
    assign w_valid  = w_inW && wr_valid;
    assign w_last   = w_inW && w_cntAtLen;
    assign wr_ready = w_inW && w_ready;

    assign b_ready  = w_inB;

    assign rd_data  = r_data;
    assign rd_valid = w_inR && r_valid;
    assign rd_last  = w_inR && r_last;
    assign r_ready  = w_inR && rd_ready;

    // Transaction sequencer: latches the command, walks the AXI channels,
    // counts beats and accumulates the completion response/protocol error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_txnAddr <= '0;
            r_txnLen  <= 8'd0;
            r_txnSize <= 3'd0;
            r_txnId   <= '0;
            r_beatCnt <= 8'd0;
            r_rspResp <= 2'b00;
            r_rspErr  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_txnAddr <= cmd_addr;
                        r_txnLen  <= cmd_len;
                        r_txnSize <= cmd_size;
                        r_txnId   <= cmd_id;
                        r_beatCnt <= 8'd0;
                        r_rspResp <= 2'b00;
                        r_rspErr  <= 1'b0;
                        r_state   <= cmd_write ? S_AW : S_AR;
                    end
                end
                S_AW: begin
                    if (aw_ready) r_state <= S_W;
                end
                S_AR: begin
                    if (ar_ready) r_state <= S_R;
                end
                S_W: begin
                    if (w_wrBeat) begin
                        if (w_cntAtLen) r_state <= S_B;
                        else r_beatCnt <= r_beatCnt + 8'd1;
                    end
                end
                S_B: begin
                    if (b_valid) begin
                        r_rspResp <= b_resp;
                        r_rspErr  <= r_rspErr | (b_id != r_txnId);
                        r_state   <= S_RSP;
                    end
                end
                S_R: begin
                    if (w_rdBeat) begin
                        if ((r_id != r_txnId) || (r_last != w_cntAtLen)) r_rspErr <= 1'b1;
                        if ((r_rspResp == 2'b00) && (r_resp != 2'b00)) r_rspResp <= r_resp;
                        if (r_beatCnt != 8'hFF) r_beatCnt <= r_beatCnt + 8'd1;
                        if (r_last) r_state <= S_RSP;
                    end
                end
                S_RSP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
